universal_shift_reg: RTL and testbench

Parametrised universal shift register built from falling-edge D flip-flops. Supports hold, shift right, shift left and parallel load, with enable, synchronous reset and a shift counter that flags each completed WIDTH-bit word. Used for serial-to-parallel and parallel-to-serial conversion between serial links and word-wide datapaths.

---
 rtl/universal_shift_reg.sv | 120 ++++++++++++
 tb/tb_universal_shift_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   Universal shift register with hold, shift right, shift left and parallel
//   load. All state changes on the falling edge of CLK. A shared shift counter
//   tracks progress through a WIDTH-bit word and pulses WORD_DONE for one
//   cycle after the edge that completes the word.
//
// Parameters
//   WIDTH    register length, 2..32
//   RST_VAL  register contents after reset
//   CNT_W    shift counter width, derived from WIDTH
//
// Ports
//   CLK        clock, falling edge active
//   RST        synchronous reset, active high
//   EN         operation enable (0 = hold everything)
//   MODE       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   SinR       serial in for right shift, enters at Q[WIDTH-1]
//   SinL       serial in for left shift, enters at Q[0]
//   Pin        parallel load data
//   Pout       register contents
//   SoutR      Q[0]
//   SoutL      Q[WIDTH-1]
//   CNT        shifts since last word boundary, load or reset
//   WORD_DONE  one-cycle strobe after the WIDTH-th shift

module universal_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              CNT_W   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [1:0]       MODE,
   input  logic             SinR,
   input  logic             SinL,
   input  logic [WIDTH-1:0] Pin,
   output logic [WIDTH-1:0] Pout,
   output logic             SoutR,
   output logic             SoutL,
   output logic [CNT_W-1:0] CNT,
   output logic             WORD_DONE
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             word_done;
   logic             word_done_nxt;
   logic             shift;

   always_comb begin
      q_nxt         = q;
      cnt_nxt       = cnt;
      word_done_nxt = 1'b0;
      shift         = 1'b0;

      if (EN) begin
         case (MODE)
            MODE_HOLD: begin
               q_nxt = q;
            end
            MODE_RIGHT: begin
               q_nxt = {SinR, q[WIDTH-1:1]};
               shift = 1'b1;
            end
            MODE_LEFT: begin
               q_nxt = {q[WIDTH-2:0], SinL};
               shift = 1'b1;
            end
            MODE_LOAD: begin
               q_nxt   = Pin;
               cnt_nxt = '0;
            end
            default: begin
               q_nxt = q;
            end
         endcase
      end

      // Both directions advance the same counter; a direction change mid-word
      // keeps the count going.
      if (shift) begin
         if (cnt == CNT_LAST) begin
            cnt_nxt       = '0;
            word_done_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_ONE;
         end
      end
   end

   always_ff @(negedge CLK) begin
      if (RST) begin
         q         <= RST_VAL;
         cnt       <= '0;
         word_done <= 1'b0;
      end else begin
         q         <= q_nxt;
         cnt       <= cnt_nxt;
         word_done <= word_done_nxt;
      end
   end

   assign Pout      = q;
   assign SoutR     = q[0];
   assign SoutL     = q[WIDTH-1];
   assign CNT       = cnt;
   assign WORD_DONE = word_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg
//   Drives an 8-bit (RST_VAL=0) and a 4-bit (RST_VAL=4'h9) instance from the
//   same inputs. A word-level model tracks both; it is compared against the
//   outputs every rising edge, and directed sequences pin literal values.

module tb_universal_shift_reg;

   logic       CLK = 1'b1;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       sinr;
   logic       sinl;
   logic [7:0] pin;

   logic [7:0] pout8;
   logic       soutr8, soutl8;
   logic [2:0] cnt8;
   logic       wd8;

   logic [3:0] pout4;
   logic       soutr4, soutl4;
   logic [1:0] cnt4;
   logic       wd4;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   universal_shift_reg #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST(rst), .EN(en), .MODE(mode), .SinR(sinr), .SinL(sinl),
      .Pin(pin), .Pout(pout8), .SoutR(soutr8), .SoutL(soutl8),
      .CNT(cnt8), .WORD_DONE(wd8)
   );

   universal_shift_reg #(.WIDTH(4), .RST_VAL(4'h9)) dut4 (
      .CLK(CLK), .RST(rst), .EN(en), .MODE(mode), .SinR(sinr), .SinL(sinl),
      .Pin(pin[3:0]), .Pout(pout4), .SoutR(soutr4), .SoutL(soutl4),
      .CNT(cnt4), .WORD_DONE(wd4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word-level model: register value as an integer, count of shifts modulo
   // the width, done flag raised when the count reaches the width.
   int unsigned mq8, mq4;
   int          mc8, mc4;
   bit          mw8, mw4;
   bit          mvalid = 1'b0;

   task automatic model_step(input int w, input int unsigned rv,
                             inout int unsigned q, inout int c, inout bit wd);
      int unsigned mask;
      bit          sh;
      mask = (32'd1 << w) - 1;
      sh   = 1'b0;
      if (rst) begin
         q = rv; c = 0; wd = 1'b0;
      end else if (!en) begin
         wd = 1'b0;
      end else begin
         wd = 1'b0;
         case (mode)
            2'd1: begin q = (q >> 1) | (int'(sinr) << (w - 1)); sh = 1'b1; end
            2'd2: begin q = ((q << 1) | int'(sinl)) & mask;     sh = 1'b1; end
            2'd3: begin q = int'(pin) & mask; c = 0; end
            default: ;
         endcase
         if (sh) begin
            c = c + 1;
            if (c == w) begin
               wd = 1'b1;
               c  = 0;
            end
         end
      end
   endtask

   always @(negedge CLK) begin
      model_step(8, 32'h00, mq8, mc8, mw8);
      model_step(4, 32'h09, mq4, mc4, mw4);
      if (rst) mvalid = 1'b1;
   end

   always @(posedge CLK) begin
      if (mvalid) begin
         chk("m8_pout",  32'(pout8),  mq8);
         chk("m8_soutr", 32'(soutr8), mq8 & 1);
         chk("m8_soutl", 32'(soutl8), (mq8 >> 7) & 1);
         chk("m8_cnt",   32'(cnt8),   32'(mc8));
         chk("m8_wd",    32'(wd8),    32'(mw8));
         chk("m4_pout",  32'(pout4),  mq4);
         chk("m4_soutr", 32'(soutr4), mq4 & 1);
         chk("m4_soutl", 32'(soutl4), (mq4 >> 3) & 1);
         chk("m4_cnt",   32'(cnt4),   32'(mc4));
         chk("m4_wd",    32'(wd4),    32'(mw4));
      end
   end

   // Apply inputs, let one falling edge pass, then settle 1 time unit.
   task automatic drive(input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [7:0] p);
      rst = r; en = e; mode = m; sinr = sr; sinl = sl; pin = p;
      @(negedge CLK);
      #1;
   endtask

   initial begin
      logic [3:0] exp_sr;

      // Reset with a load requested in the same cycle
      drive(1, 0, 2'b00, 0, 0, 8'h00);
      drive(0, 1, 2'b11, 0, 0, 8'hFF);
      chk("preload", 32'(pout8), 32'hFF);
      drive(1, 1, 2'b11, 0, 0, 8'h5A);
      chk("rst_pout8", 32'(pout8), 32'h00);
      chk("rst_cnt8",  32'(cnt8),  32'h0);
      chk("rst_wd8",   32'(wd8),   32'h0);
      chk("rst_pout4", 32'(pout4), 32'h9);

      // SISO right on the 4-bit instance
      drive(0, 1, 2'b01, 1, 0, 8'h00);
      drive(0, 1, 2'b01, 0, 0, 8'h00);
      drive(0, 1, 2'b01, 1, 0, 8'h00);
      chk("siso_wd_early", 32'(wd4), 32'h0);
      drive(0, 1, 2'b01, 1, 0, 8'h00);
      chk("siso_pout4", 32'(pout4), 32'hD);
      chk("siso_cnt4",  32'(cnt4),  32'h0);
      chk("siso_wd4",   32'(wd4),   32'h1);
      chk("siso_sout4", 32'(soutr4), 32'h1);
      exp_sr = 4'b1101;
      for (int i = 1; i < 4; i++) begin
         drive(0, 1, 2'b01, 0, 0, 8'h00);
         chk("siso_soutr", 32'(soutr4), 32'(exp_sr[i]));
         if (i == 1) chk("siso_wd_once", 32'(wd4), 32'h0);
      end

      // Load then shift left on the 8-bit instance
      drive(0, 1, 2'b11, 0, 0, 8'hA5);
      chk("ld_pout", 32'(pout8), 32'hA5);
      chk("ld_cnt",  32'(cnt8),  32'h0);
      drive(0, 1, 2'b10, 0, 0, 8'h00);
      chk("sl1_pout", 32'(pout8), 32'h4A); chk("sl1_soutl", 32'(soutl8), 0); chk("sl1_cnt", 32'(cnt8), 1);
      drive(0, 1, 2'b10, 0, 0, 8'h00);
      chk("sl2_pout", 32'(pout8), 32'h94); chk("sl2_soutl", 32'(soutl8), 1); chk("sl2_cnt", 32'(cnt8), 2);
      drive(0, 1, 2'b10, 0, 0, 8'h00);
      chk("sl3_pout", 32'(pout8), 32'h28); chk("sl3_soutl", 32'(soutl8), 0); chk("sl3_cnt", 32'(cnt8), 3);

      // Enable and hold gating
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(0, 0, 2'b01, 1, 1, 8'hFF);
         else       drive(0, 1, 2'b00, 1, 1, 8'hFF);
         chk("gate_pout", 32'(pout8), 32'h28);
         chk("gate_cnt",  32'(cnt8),  32'h3);
         chk("gate_wd",   32'(wd8),   32'h0);
      end

      // Wrap across two words
      drive(0, 1, 2'b11, 0, 0, 8'h3C);
      for (int i = 1; i <= 16; i++) begin
         drive(0, 1, 2'b01, 1'($urandom_range(0, 1)), 0, 8'h00);
         chk("wrap_cnt", 32'(cnt8), 32'(i % 8));
         chk("wrap_wd",  32'(wd8),  32'((i == 8) || (i == 16)));
      end

      // Load at edge 5 restarts the word
      drive(0, 1, 2'b11, 0, 0, 8'h11);
      for (int i = 1; i <= 13; i++) begin
         if (i == 5) drive(0, 1, 2'b11, 0, 0, 8'h77);
         else        drive(0, 1, 2'b01, 0, 0, 8'h00);
         if (i >= 5) begin
            chk("restart_cnt", 32'(cnt8), 32'((i - 5) % 8));
            chk("restart_wd",  32'(wd8),  32'(i == 13));
         end
      end

      // Reset mid-word
      drive(0, 1, 2'b11, 0, 0, 8'hC3);
      drive(0, 1, 2'b01, 1, 0, 8'h00);
      drive(0, 1, 2'b01, 1, 0, 8'h00);
      chk("mid_cnt", 32'(cnt8), 32'h2);
      drive(1, 1, 2'b01, 1, 0, 8'h00);
      chk("mid_rst_pout", 32'(pout8), 32'h00);
      chk("mid_rst_cnt",  32'(cnt8),  32'h0);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, 2'b01, 1, 0, 8'h00);
         chk("mid_wd", 32'(wd8), 32'(i == 8));
      end

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 7) != 0),
               2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
